sigma_delta_adc_capture_ctrl: RTL and testbench

Burst-capture sequencer for the sigma-delta ADC.
- Holds the ADC in reset (power save) while idle. On start, releases it and discards the first SETTLE_SAMPLES outputs while the CIC, DC-block and FIR settle.
- Then captures burst_len samples into a small FIFO and presents them on a valid/ready stream.
- Sits between the ADC's adc_output/adc_valid and the downstream consumer (DMA, UART packer, etc.).

---
 rtl/sigma_delta_pkg.sv | 17 +
 rtl/sigma_delta_sync_fifo.sv | 61 ++++++
 rtl/sigma_delta_adc_capture_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sigma_delta_adc_capture_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// Shared types and constants for the sigma-delta ADC burst-capture controller.
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DRAIN
    } cap_state_t;

    localparam int unsigned ADC_BITLEN_DEF = 16;

    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sigma_delta_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible one cycle after
// a write into an empty FIFO. DEPTH must be a power of two, at least 2.
module sigma_delta_sync_fifo
    import sigma_delta_pkg::*;
#(
    parameter int unsigned WIDTH = ADC_BITLEN_DEF,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = fifo_ptr_w(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign do_rd = rd_en && !empty;
    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigma_delta_adc_capture_ctrl.sv
// Burst-capture sequencer: settles the ADC, captures a burst into a FWFT FIFO and
// streams it out. Define ADC_CAPTURE_FIRST_EN to add the m_first burst-start marker.
module sigma_delta_adc_capture_ctrl
    import sigma_delta_pkg::*;
#(
    parameter int unsigned ADC_BITLEN     = ADC_BITLEN_DEF,
    parameter int unsigned SETTLE_SAMPLES = 8,
    parameter int unsigned BURST_W        = 16,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [BURST_W-1:0]    burst_len,
    output logic                  adc_rst,
    input  logic [ADC_BITLEN-1:0] adc_output,
    input  logic                  adc_valid,
    output logic [ADC_BITLEN-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
`ifdef ADC_CAPTURE_FIRST_EN
    output logic                  m_first,
`endif
    output logic [BURST_W-1:0]    sample_count
);
`ifdef ADC_CAPTURE_FIRST_EN
    localparam int unsigned FW = ADC_BITLEN + 1;
`else
    localparam int unsigned FW = ADC_BITLEN;
`endif
    localparam int unsigned SW = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);

    cap_state_t        state;
    cap_state_t        state_next;
    logic              done_next;
    logic [BURST_W-1:0] burst_reg;
    logic [SW-1:0]     settle_cnt;
    logic [BURST_W-1:0] count_inc;
    logic              capture;
    logic              last;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic              launch;
    logic [FW-1:0]     wr_data;
    logic [FW-1:0]     rd_data;
    logic              full;
    logic              empty;

    assign m_valid   = !empty;
    assign pop       = m_valid && m_ready;
    assign capture   = (state == CAPTURE) && adc_valid;
    assign count_inc = (sample_count == '1) ? sample_count : sample_count + 1'b1;
    assign last      = capture && (burst_reg != '0) && (count_inc == burst_reg);
    assign wr_en     = capture && (!full || pop);
    assign drop      = capture && full && !pop;
    assign launch    = (state == IDLE) && (state_next != IDLE);

`ifdef ADC_CAPTURE_FIRST_EN
    logic first_pending;

    assign wr_data = {first_pending, adc_output};
    assign m_data  = rd_data[ADC_BITLEN-1:0];
    assign m_first = rd_data[ADC_BITLEN];

    // Marker rides on the first word actually written, so a dropped first capture passes it on.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_pending <= 1'b0;
        end else if (launch) begin
            first_pending <= 1'b1;
        end else if (wr_en) begin
            first_pending <= 1'b0;
        end
    end
`else
    assign wr_data = adc_output;
    assign m_data  = rd_data;
`endif

    sigma_delta_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (m_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                // done is still high on the first IDLE cycle; a start there is ignored
                if (start && !done) begin
                    state_next = (SETTLE_SAMPLES == 0) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_next = DRAIN;
                end else if (adc_valid && (settle_cnt == SETTLE_LAST)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (stop || last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            sample_count <= '0;
            burst_reg    <= '0;
            settle_cnt   <= '0;
        end else begin
            adc_rst <= (state_next == IDLE) || (state_next == DRAIN);
            busy    <= (state_next != IDLE);
            done    <= done_next;
            if (launch) begin
                burst_reg    <= burst_len;
                overflow     <= 1'b0;
                sample_count <= '0;
                settle_cnt   <= '0;
            end else begin
                if ((state == SETTLE) && adc_valid) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                if (capture) begin
                    sample_count <= count_inc;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_adc_capture_ctrl.sv
// Self-checking bench for sigma_delta_adc_capture_ctrl: burst table plus hand-written corner sequences.
module tb_sigma_delta_adc_capture_ctrl;
    localparam int unsigned W     = 16;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, adc_valid, m_ready;
    logic [BW-1:0] burst_len;
    logic [W-1:0]  adc_output;
    logic          adc_rst, m_valid, busy, done, overflow;
    logic [W-1:0]  m_data;
    logic [BW-1:0] sample_count;

    logic          z_start, z_ready;
    logic          z_adc_rst, z_m_valid, z_busy, z_done, z_overflow;
    logic [W-1:0]  z_m_data;
    logic [BW-1:0] z_sample_count;
`ifdef ADC_CAPTURE_FIRST_EN
    logic          m_first, z_m_first;
`endif

    sigma_delta_adc_capture_ctrl #(
        .ADC_BITLEN (W), .SETTLE_SAMPLES (8), .BURST_W (BW), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .stop (stop), .burst_len (burst_len),
        .adc_rst (adc_rst), .adc_output (adc_output), .adc_valid (adc_valid),
        .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready), .busy (busy),
        .done (done), .overflow (overflow),
`ifdef ADC_CAPTURE_FIRST_EN
        .m_first (m_first),
`endif
        .sample_count (sample_count)
    );

    sigma_delta_adc_capture_ctrl #(
        .ADC_BITLEN (W), .SETTLE_SAMPLES (0), .BURST_W (BW), .FIFO_DEPTH (4)
    ) dut_nosettle (
        .clk (clk), .rst (rst), .start (z_start), .stop (stop), .burst_len (burst_len),
        .adc_rst (z_adc_rst), .adc_output (adc_output), .adc_valid (adc_valid),
        .m_data (z_m_data), .m_valid (z_m_valid), .m_ready (z_ready), .busy (z_busy),
        .done (z_done), .overflow (z_overflow),
`ifdef ADC_CAPTURE_FIRST_EN
        .m_first (z_m_first),
`endif
        .sample_count (z_sample_count)
    );

    typedef struct {
        logic [BW-1:0] blen;
        int unsigned   ncap;
        logic          ready;
        logic [BW-1:0] exp_count;
        logic          exp_ovf;
        int unsigned   exp_words;
    } vec_t;

    vec_t          vecs[5];
    logic [W-1:0]  exp_q[$];
    int unsigned   pops;
    int unsigned   total;
    int unsigned   passed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // One clock: score any pop at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (m_valid && m_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL pop_unexpected: got m_data=%0d required no word", m_data);
            end else begin
                check("pop_data", m_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic drive_valid(input logic [W-1:0] v);
        adc_output = v;
        adc_valid  = 1'b1;
        cycle();
        adc_valid  = 1'b0;
    endtask

    task automatic pulse_start(input logic [BW-1:0] blen);
        burst_len = blen;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        check("start_busy", busy, 1);
        check("start_adc_rst", adc_rst, 0);
    endtask

    task automatic settle();
        for (int unsigned i = 0; i < 8; i++) begin
            drive_valid(W'(i));
            idle(2);
        end
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!done && n < 300) begin
            cycle();
            n++;
        end
        check({name, "_done"}, done, 1);
        check({name, "_empty_at_done"}, m_valid, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check({name, "_done_pulse"}, done, 0);
        check({name, "_start_at_done_ignored"}, busy, 0);
        check({name, "_idle_adc_rst"}, adc_rst, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned pops0 = pops;
        int unsigned occ = 0;
        m_ready = v.ready;
        pulse_start(v.blen);
        settle();
        for (int unsigned i = 0; i < v.ncap; i++) begin
            if (v.ready || occ < DEPTH) begin
                exp_q.push_back(W'(8 + i));
                if (!v.ready) occ++;
            end
            drive_valid(W'(8 + i));
            if (i + 1 < v.ncap) idle(3);
        end
        check("vec_drain_adc_rst", adc_rst, 1);
        if (!v.ready) begin
            idle(5);
            check("vec_hold_busy", busy, 1);
            check("vec_hold_no_done", done, 0);
            m_ready = 1'b1;
        end
        wait_done("vec");
        check("vec_sample_count", sample_count, v.exp_count);
        check("vec_overflow", overflow, v.exp_ovf);
        check("vec_words", pops - pops0, v.exp_words);
        check("vec_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int unsigned pops0;
        int unsigned seen;
        total = 0; passed = 0; pops = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; adc_valid = 1'b0; m_ready = 1'b1;
        burst_len = '0; adc_output = '0; z_start = 1'b0; z_ready = 1'b0;

        vecs[0] = '{blen: 4,  ncap: 4,  ready: 1'b1, exp_count: 4,  exp_ovf: 1'b0, exp_words: 4};
        vecs[1] = '{blen: 20, ncap: 20, ready: 1'b0, exp_count: 20, exp_ovf: 1'b1, exp_words: 16};
        vecs[2] = '{blen: 1,  ncap: 1,  ready: 1'b1, exp_count: 1,  exp_ovf: 1'b0, exp_words: 1};
        vecs[3] = '{blen: 16, ncap: 16, ready: 1'b0, exp_count: 16, exp_ovf: 1'b0, exp_words: 16};
        vecs[4] = '{blen: 17, ncap: 17, ready: 1'b0, exp_count: 17, exp_ovf: 1'b1, exp_words: 16};

        idle(2);
        check("rst_adc_rst", adc_rst, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sample_count", sample_count, 0);
        check("rst_m_data", m_data, 0);
        rst = 1'b0;
        idle(2);

        for (int unsigned k = 0; k < 5; k++) run_vec(vecs[k]);

        // stop in IDLE, start during CAPTURE, stop coincident with a sample, sample in DRAIN
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_idle_busy", busy, 0);
        check("stop_idle_adc_rst", adc_rst, 1);
        pops0 = pops;
        m_ready = 1'b1;
        pulse_start(0);
        settle();
        for (int unsigned i = 0; i < 5; i++) begin
            exp_q.push_back(W'(100 + i));
            drive_valid(W'(100 + i));
            idle(3);
            if (i == 1) begin
                burst_len = 3;
                start = 1'b1;
                cycle();
                start = 1'b0;
                check("start_busy_ignored", busy, 1);
            end
        end
        exp_q.push_back(W'(105));
        adc_output = 105;
        adc_valid  = 1'b1;
        stop       = 1'b1;
        cycle();
        adc_valid  = 1'b0;
        stop       = 1'b0;
        check("stop_drain_adc_rst", adc_rst, 1);
        drive_valid(W'(999));
        wait_done("stop");
        check("stop_sample_count", sample_count, 6);
        check("stop_overflow", overflow, 0);
        check("stop_words", pops - pops0, 6);

        // synchronous reset mid-capture with words queued
        m_ready = 1'b0;
        pulse_start(10);
        settle();
        for (int unsigned i = 0; i < 3; i++) begin
            drive_valid(W'(200 + i));
            idle(2);
        end
        check("abort_pre_valid", m_valid, 1);
        check("abort_pre_count", sample_count, 3);
        rst = 1'b1;
        cycle();
        check("abort_m_valid", m_valid, 0);
        check("abort_adc_rst", adc_rst, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sample_count", sample_count, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        seen = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            cycle();
            if (done || m_valid) seen++;
        end
        check("abort_quiet", seen, 0);

        // no settling: first ADC sample is captured immediately
        burst_len = 3;
        z_start = 1'b1;
        cycle();
        z_start = 1'b0;
        check("nosettle_adc_rst", z_adc_rst, 0);
        check("nosettle_busy", z_busy, 1);
        for (int unsigned i = 0; i < 3; i++) begin
            drive_valid(W'(300 + i));
            idle(1);
        end
        check("nosettle_drain_adc_rst", z_adc_rst, 1);
        check("nosettle_count", z_sample_count, 3);
        check("nosettle_head_valid", z_m_valid, 1);
        for (int unsigned i = 0; i < 3; i++) begin
            check("nosettle_data", z_m_data, 300 + i);
`ifdef ADC_CAPTURE_FIRST_EN
            check("nosettle_first", z_m_first, (i == 0) ? 1 : 0);
`endif
            z_ready = 1'b1;
            cycle();
        end
        check("nosettle_empty", z_m_valid, 0);
        seen = 0;
        for (int unsigned i = 0; i < 20 && seen == 0; i++) begin
            if (z_done) seen = 1;
            else cycle();
        end
        check("nosettle_done", seen, 1);
        cycle();
        check("nosettle_idle", z_busy, 0);
        check("nosettle_overflow", z_overflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
